// File: rtl/drum_step_sequencer_if.sv
// rtl/drum_step_sequencer_if.sv - control, pattern-edit and trigger signals of the drum step sequencer
// loop_last exists only when DRUM_SEQ_LOOP_LEN_EN is defined.
interface drum_step_sequencer_if #(
    parameter int NUM_VOICES = 4,
    parameter int STEP_W     = 4
);
    logic                  step_tick;
    logic                  play;
    logic                  stop;
    logic                  wr_en;
    logic [1:0]            wr_voice;
    logic [STEP_W-1:0]     wr_step;
    logic                  wr_val;
    logic                  clear_all;
    logic [NUM_VOICES-1:0] trig;
    logic [STEP_W-1:0]     step_idx;
    logic                  playing;
`ifdef DRUM_SEQ_LOOP_LEN_EN
    logic [STEP_W-1:0]     loop_last;
`endif

    modport master (
`ifdef DRUM_SEQ_LOOP_LEN_EN
        output loop_last,
`endif
        output step_tick, play, stop, wr_en, wr_voice, wr_step, wr_val, clear_all,
        input  trig, step_idx, playing
    );

    modport slave (
`ifdef DRUM_SEQ_LOOP_LEN_EN
        input  loop_last,
`endif
        input  step_tick, play, stop, wr_en, wr_voice, wr_step, wr_val, clear_all,
        output trig, step_idx, playing
    );
endinterface

// File: rtl/drum_step_sequencer.sv
// rtl/drum_step_sequencer.sv - pattern-driven drum step sequencer with per-voice trigger pulses
// Optional DRUM_SEQ_LOOP_LEN_EN adds a programmable loop end (loop_last).
module drum_step_sequencer #(
    parameter int NUM_VOICES  = 4,
    parameter int STEP_W      = 4,
    parameter int TRIG_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    drum_step_sequencer_if.slave bus
);
    localparam int NUM_STEPS = 1 << STEP_W;

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t                state;
    logic [NUM_STEPS-1:0]  pattern [NUM_VOICES];
    logic [CNT_W-1:0]      trig_cnt [NUM_VOICES];
    logic [NUM_VOICES-1:0] trig_q;
    logic [STEP_W-1:0]     step_q;
    logic                  playing_q;
    logic [STEP_W-1:0]     next_step;
    logic [STEP_W-1:0]     fire_col;
    logic                  fire;

    always_comb begin
        next_step = '0;
`ifdef DRUM_SEQ_LOOP_LEN_EN
        // >= so that lowering loop_last below the current step still returns to 0
        next_step = (step_q >= bus.loop_last) ? '0 : step_q + 1'b1;
`else
        next_step = step_q + 1'b1;
`endif
        fire     = bus.step_tick && !bus.stop && (state != IDLE);
        fire_col = (state == ARMED) ? '0 : next_step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step_q    <= '0;
            trig_q    <= '0;
            playing_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                trig_cnt[v] <= '0;
                pattern[v]  <= '0;
            end
        end else begin
            // Pattern reads below see the pre-write value, so an edit to the firing column lands next visit
            if (bus.clear_all) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    pattern[v] <= '0;
            end else if (bus.wr_en) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (int'(bus.wr_voice) == v)
                        pattern[v][bus.wr_step] <= bus.wr_val;
            end

            if (bus.stop) begin
                trig_q <= '0;
                for (int v = 0; v < NUM_VOICES; v++)
                    trig_cnt[v] <= '0;
            end else begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (fire && pattern[v][fire_col]) begin
                        trig_cnt[v] <= CNT_W'(TRIG_CYCLES);
                        trig_q[v]   <= 1'b1;
                    end else if (trig_cnt[v] != '0) begin
                        trig_cnt[v] <= trig_cnt[v] - 1'b1;
                        trig_q[v]   <= (trig_cnt[v] != CNT_W'(1));
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (bus.play && !bus.stop) begin
                        state     <= ARMED;
                        step_q    <= '0;
                        playing_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bus.stop) begin
                        state     <= IDLE;
                        step_q    <= '0;
                        playing_q <= 1'b0;
                    end else if (bus.step_tick) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state     <= IDLE;
                        step_q    <= '0;
                        playing_q <= 1'b0;
                    end else if (bus.step_tick) begin
                        step_q <= next_step;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step_q    <= '0;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig     = trig_q;
    assign bus.step_idx = step_q;
    assign bus.playing  = playing_q;
endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb/tb_drum_step_sequencer.sv - directed self-checking bench for drum_step_sequencer
// dut_a uses TRIG_CYCLES=5, dut_b TRIG_CYCLES=10; both see identical stimulus.
module tb_drum_step_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    drum_step_sequencer_if #(.NUM_VOICES(4), .STEP_W(4)) bus_a ();
    drum_step_sequencer_if #(.NUM_VOICES(4), .STEP_W(4)) bus_b ();

    assign bus_b.step_tick = bus_a.step_tick;
    assign bus_b.play      = bus_a.play;
    assign bus_b.stop      = bus_a.stop;
    assign bus_b.wr_en     = bus_a.wr_en;
    assign bus_b.wr_voice  = bus_a.wr_voice;
    assign bus_b.wr_step   = bus_a.wr_step;
    assign bus_b.wr_val    = bus_a.wr_val;
    assign bus_b.clear_all = bus_a.clear_all;
`ifdef DRUM_SEQ_LOOP_LEN_EN
    assign bus_b.loop_last = bus_a.loop_last;
`endif

    drum_step_sequencer #(.NUM_VOICES(4), .STEP_W(4), .TRIG_CYCLES(5), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    drum_step_sequencer #(.NUM_VOICES(4), .STEP_W(4), .TRIG_CYCLES(10), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus_a.step_tick = 1'b1;
        cyc();
        bus_a.step_tick = 1'b0;
    endtask

    task automatic do_play();
        bus_a.play = 1'b1;
        cyc();
        bus_a.play = 1'b0;
    endtask

    task automatic do_stop();
        bus_a.stop = 1'b1;
        cyc();
        bus_a.stop = 1'b0;
    endtask

    task automatic do_clear();
        bus_a.clear_all = 1'b1;
        cyc();
        bus_a.clear_all = 1'b0;
    endtask

    task automatic write_cell(input logic [1:0] v, input logic [3:0] s, input logic val);
        bus_a.wr_en    = 1'b1;
        bus_a.wr_voice = v;
        bus_a.wr_step  = s;
        bus_a.wr_val   = val;
        cyc();
        bus_a.wr_en    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        if (bus_a.playing !== 1'b0) begin n_bad++; $display("FAIL reset_playing: got %0h expected 0", bus_a.playing); end
        n_cmp++;
        if (bus_a.step_idx !== 4'd0) begin n_bad++; $display("FAIL reset_step: got %0h expected 0", bus_a.step_idx); end
        n_cmp++;
        if (bus_a.trig !== 4'd0) begin n_bad++; $display("FAIL reset_trig: got %0h expected 0", bus_a.trig); end
        n_cmp++;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic_loop();
        logic [3:0] exp_step;
        logic       exp_hit;
        int         width;
        write_cell(2'd0, 4'd0, 1'b1);
        write_cell(2'd0, 4'd4, 1'b1);
        write_cell(2'd0, 4'd8, 1'b1);
        write_cell(2'd0, 4'd12, 1'b1);
        do_play();
        if (bus_a.playing !== 1'b1) begin n_bad++; $display("FAIL play_playing: got %0h expected 1", bus_a.playing); end
        n_cmp++;
        if (bus_a.trig !== 4'd0) begin n_bad++; $display("FAIL armed_trig: got %0h expected 0", bus_a.trig); end
        n_cmp++;
        for (int k = 1; k <= 17; k++) begin
            exp_step = 4'((k - 1) % 16);
            exp_hit  = ((k - 1) % 4 == 0);
            do_tick();
            if (bus_a.step_idx !== exp_step) begin
                n_bad++; $display("FAIL loop_step tick %0d: got %0d expected %0d", k, bus_a.step_idx, exp_step);
            end
            n_cmp++;
            if (bus_a.trig[0] !== exp_hit) begin
                n_bad++; $display("FAIL loop_trig_rise tick %0d: got %0h expected %0h", k, bus_a.trig[0], exp_hit);
            end
            n_cmp++;
            width = int'(bus_a.trig[0]);
            for (int i = 0; i < 99; i++) begin
                cyc();
                width += int'(bus_a.trig[0]);
            end
            if (width !== (exp_hit ? 5 : 0)) begin
                n_bad++; $display("FAIL loop_width tick %0d: got %0d expected %0d", k, width, exp_hit ? 5 : 0);
            end
            n_cmp++;
        end
        do_stop();
    endtask

    task automatic test_play_stop();
        bus_a.play = 1'b1;
        bus_a.stop = 1'b1;
        cyc();
        bus_a.play = 1'b0;
        bus_a.stop = 1'b0;
        if (bus_a.playing !== 1'b0) begin n_bad++; $display("FAIL play_stop_playing: got %0h expected 0", bus_a.playing); end
        n_cmp++;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            if (bus_a.trig !== 4'd0 || bus_a.playing !== 1'b0) begin
                n_bad++; $display("FAIL idle_tick %0d: got trig %0h playing %0h expected 0 0", k, bus_a.trig, bus_a.playing);
            end
            n_cmp++;
        end
        do_play();
        for (int k = 0; k < 5; k++) begin
            do_tick();
            if (k < 4) cyc();
        end
        if (bus_a.trig[0] !== 1'b1 || bus_a.step_idx !== 4'd4) begin
            n_bad++; $display("FAIL pre_stop: got trig0 %0h step %0d expected 1 4", bus_a.trig[0], bus_a.step_idx);
        end
        n_cmp++;
        do_stop();
        if (bus_a.trig !== 4'd0 || bus_a.step_idx !== 4'd0 || bus_a.playing !== 1'b0) begin
            n_bad++; $display("FAIL stop_mid_pulse: got trig %0h step %0d playing %0h expected 0 0 0",
                              bus_a.trig, bus_a.step_idx, bus_a.playing);
        end
        n_cmp++;
    endtask

    task automatic test_retrigger();
        int  hi_a, hi_b;
        logic fell_a, fell_b, gap_a, gap_b;
        hi_a = 0; hi_b = 0;
        fell_a = 1'b0; fell_b = 1'b0; gap_a = 1'b0; gap_b = 1'b0;
        do_clear();
        write_cell(2'd1, 4'd0, 1'b1);
        write_cell(2'd1, 4'd1, 1'b1);
        do_play();
        for (int i = 0; i < 30; i++) begin
            bus_a.step_tick = (i == 0 || i == 4);
            cyc();
            bus_a.step_tick = 1'b0;
            if (bus_a.trig[1]) begin hi_a++; if (fell_a) gap_a = 1'b1; end
            else if (hi_a > 0) fell_a = 1'b1;
            if (bus_b.trig[1]) begin hi_b++; if (fell_b) gap_b = 1'b1; end
            else if (hi_b > 0) fell_b = 1'b1;
        end
        if (hi_b !== 14 || gap_b !== 1'b0) begin
            n_bad++; $display("FAIL retrig_t10: got width %0d gap %0h expected 14 0", hi_b, gap_b);
        end
        n_cmp++;
        if (hi_a !== 9 || gap_a !== 1'b0) begin
            n_bad++; $display("FAIL retrig_t5: got width %0d gap %0h expected 9 0", hi_a, gap_a);
        end
        n_cmp++;
        do_stop();
    endtask

    task automatic test_read_before_write();
        do_clear();
        do_play();
        for (int k = 0; k < 3; k++) begin
            do_tick();
            cyc();
        end
        bus_a.step_tick = 1'b1;
        bus_a.wr_en     = 1'b1;
        bus_a.wr_voice  = 2'd2;
        bus_a.wr_step   = 4'd3;
        bus_a.wr_val    = 1'b1;
        cyc();
        bus_a.step_tick = 1'b0;
        bus_a.wr_en     = 1'b0;
        if (bus_a.step_idx !== 4'd3 || bus_a.trig[2] !== 1'b0) begin
            n_bad++; $display("FAIL rbw_first_visit: got step %0d trig2 %0h expected 3 0", bus_a.step_idx, bus_a.trig[2]);
        end
        n_cmp++;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            do_tick();
            if (bus_a.trig[2] !== (k == 16)) begin
                n_bad++; $display("FAIL rbw_tick %0d: got trig2 %0h expected %0h", k, bus_a.trig[2], (k == 16));
            end
            n_cmp++;
        end
        if (bus_a.step_idx !== 4'd3) begin n_bad++; $display("FAIL rbw_step: got %0d expected 3", bus_a.step_idx); end
        n_cmp++;
        do_stop();
    endtask

    task automatic test_clear_priority();
        int hits;
        hits = 0;
        bus_a.clear_all = 1'b1;
        bus_a.wr_en     = 1'b1;
        bus_a.wr_voice  = 2'd0;
        bus_a.wr_step   = 4'd5;
        bus_a.wr_val    = 1'b1;
        cyc();
        bus_a.clear_all = 1'b0;
        bus_a.wr_en     = 1'b0;
        do_play();
        for (int k = 0; k < 16; k++) begin
            do_tick();
            if (bus_a.trig != 4'd0) hits++;
            for (int i = 0; i < 5; i++) begin
                cyc();
                if (bus_a.trig != 4'd0) hits++;
            end
        end
        if (hits !== 0) begin n_bad++; $display("FAIL clear_prio_trig: got %0d active cycles expected 0", hits); end
        n_cmp++;
        if (bus_a.step_idx !== 4'd15) begin n_bad++; $display("FAIL clear_prio_step: got %0d expected 15", bus_a.step_idx); end
        n_cmp++;
        do_stop();
    endtask

`ifdef DRUM_SEQ_LOOP_LEN_EN
    task automatic test_loop_len();
        logic [3:0] exp_step;
        bus_a.loop_last = 4'd3;
        do_play();
        for (int k = 0; k < 8; k++) begin
            exp_step = 4'(k % 4);
            do_tick();
            if (bus_a.step_idx !== exp_step) begin
                n_bad++; $display("FAIL loop_len_step %0d: got %0d expected %0d", k, bus_a.step_idx, exp_step);
            end
            n_cmp++;
        end
        bus_a.loop_last = 4'd1;
        do_tick();
        if (bus_a.step_idx !== 4'd0) begin n_bad++; $display("FAIL loop_len_lowered: got %0d expected 0", bus_a.step_idx); end
        n_cmp++;
        do_stop();
        bus_a.loop_last = 4'd15;
    endtask
`endif

    initial begin
        reset           = 1'b1;
        bus_a.step_tick = 1'b0;
        bus_a.play      = 1'b0;
        bus_a.stop      = 1'b0;
        bus_a.wr_en     = 1'b0;
        bus_a.wr_voice  = 2'd0;
        bus_a.wr_step   = 4'd0;
        bus_a.wr_val    = 1'b0;
        bus_a.clear_all = 1'b0;
`ifdef DRUM_SEQ_LOOP_LEN_EN
        bus_a.loop_last = 4'd15;
`endif
        test_reset();
        test_basic_loop();
        test_play_stop();
        test_retrigger();
        test_read_before_write();
        test_clear_priority();
`ifdef DRUM_SEQ_LOOP_LEN_EN
        test_loop_len();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
